// File: rtl/adder_sequencer.sv
// Wide add/subtract built by time-multiplexing one 4-bit ripple-carry adder,
// one nibble per cycle LSB first, with valid/ready handshakes on both sides.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[4];
endmodule

module adder_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   CIN,
  input  logic                   SUB,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [4*NIBBLES-1:0]   SUM,
  output logic                   COUT,
  output logic                   OVF
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;   // effective B: already inverted for subtract
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [3:0]    nib_a, nib_b, rca_sum;
  logic          rca_cout;
  logic          last_nib;

  assign nib_a    = a_q[{idx_q, 2'b00} +: 4];
  assign nib_b    = b_q[{idx_q, 2'b00} +: 4];
  assign last_nib = (idx_q == IW'(NIBBLES - 1));

  ripple_carry_adder_4bit u_rca (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          a_d     = A;
          b_d     = SUB ? ~B : B;
          carry_d = SUB | CIN;   // subtract is A + ~B + 1
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = rca_sum;
        carry_d = rca_cout;
        if (last_nib) begin
          cout_d  = rca_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (rca_sum[3] != a_q[W-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign IN_READY  = RST_N && (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign SUM       = sum_q;
  assign COUT      = cout_q;
  assign OVF       = ovf_q;
endmodule

// File: tb/tb_adder_sequencer.sv
// Self-checking bench for adder_sequencer (NIBBLES=4): directed corner cases
// plus randomized traffic against an arithmetic reference model.

module tb_adder_sequencer;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A, B;
  logic         CIN, SUB;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] SUM;
  logic         COUT, OVF;

  int checks = 0;
  int errors = 0;

  adder_sequencer #(.NIBBLES(NIB)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .CIN       (CIN),
    .SUB       (SUB),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .SUM       (SUM),
    .COUT      (COUT),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  // Reference: plain unsigned / signed integer arithmetic on whole words.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic cin, input logic sub,
                                    output logic [W-1:0] s, output logic co,
                                    output logic ov);
    longint ua, ub, u, sa, sb, r;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= (64'sd1 << (W-1))) ? ua - (64'sd1 << W) : ua;
    sb = (ub >= (64'sd1 << (W-1))) ? ub - (64'sd1 << W) : ub;
    if (!sub) begin
      u  = ua + ub + longint'(cin);
      co = (u >= (64'sd1 << W));
      r  = sa + sb + longint'(cin);
    end else begin
      u  = ua - ub;
      co = (ua >= ub);
      r  = sa - sb;
    end
    s  = W'(u);
    ov = (r >= (64'sd1 << (W-1))) || (r < -(64'sd1 << (W-1)));
  endfunction

  // Called just after a negedge; returns just after the negedge following the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    A = a; B = b; CIN = cin; SUB = sub; IN_VALID = 1'b1;
    while (IN_READY !== 1'b1 && n < 50) begin
      @(posedge CLK); @(negedge CLK); n++;
    end
    if (n >= 50) begin
      to = 1'b1;
      IN_VALID = 1'b0;
      return;
    end
    @(posedge CLK); @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  // lat counts the accept cycle as 1.
  task automatic wait_result(output int lat, output bit to);
    lat = 1;
    while (OUT_VALID !== 1'b1 && lat < 50) begin
      @(posedge CLK); @(negedge CLK); lat++;
    end
    to = (OUT_VALID !== 1'b1);
  endtask

  task automatic pop();
    OUT_READY = 1'b1;
    @(posedge CLK); @(negedge CLK);
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
    A = '1; B = '1; CIN = 1'b1; SUB = 1'b0;
    repeat (3) begin @(posedge CLK); @(negedge CLK); end
    checks++; if (IN_READY !== 1'b0)  begin errors++; $display("FAIL rst_in_ready: got %b want 0", IN_READY); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", OUT_VALID); end
    checks++; if (SUM !== '0)         begin errors++; $display("FAIL rst_sum: got %h want 0", SUM); end
    checks++; if (COUT !== 1'b0 || OVF !== 1'b0) begin errors++; $display("FAIL rst_flags: got cout=%b ovf=%b want 0 0", COUT, OVF); end
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    RST_N = 1'b1;
    #1;
    checks++; if (IN_READY !== 1'b1)  begin errors++; $display("FAIL rst_release_ready: got %b want 1", IN_READY); end
    @(negedge CLK);
  endtask

  // Directed table: ripple, wrap, overflow and subtract corners.
  task automatic test_directed();
    logic [W-1:0] ta[6], tb[6], es;
    logic         tc[6], ts[6], ec, eo;
    bit           to;
    int           lat;
    ta = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234};
    tb = '{16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001, 16'h1111};
    tc = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b0};
    ts = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
    for (int i = 0; i < 6; i++) begin
      ref_model(ta[i], tb[i], tc[i], ts[i], es, ec, eo);
      start_op(ta[i], tb[i], tc[i], ts[i], to);
      checks++; if (to) begin errors++; $display("FAIL dir_accept[%0d]: timed out waiting for IN_READY", i); continue; end
      checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL dir_busy[%0d]: IN_READY got %b want 0", i, IN_READY); end
      wait_result(lat, to);
      checks++; if (to) begin errors++; $display("FAIL dir_done[%0d]: timed out waiting for OUT_VALID", i); continue; end
      checks++; if (lat != NIB + 1) begin errors++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, NIB + 1); end
      checks++; if (SUM !== es)  begin errors++; $display("FAIL dir_sum[%0d]: got %h want %h", i, SUM, es); end
      checks++; if (COUT !== ec) begin errors++; $display("FAIL dir_cout[%0d]: got %b want %b", i, COUT, ec); end
      checks++; if (OVF !== eo)  begin errors++; $display("FAIL dir_ovf[%0d]: got %b want %b", i, OVF, eo); end
      pop();
      checks++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
        errors++; $display("FAIL dir_pop[%0d]: got out_valid=%b in_ready=%b want 0 1", i, OUT_VALID, IN_READY);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held, es;
    logic         ec, eo;
    bit           to;
    int           lat;
    start_op(16'h4321, 16'h0F0F, 1'b0, 1'b0, to);
    wait_result(lat, to);
    checks++; if (to) begin errors++; $display("FAIL bp_done: timed out waiting for OUT_VALID"); return; end
    held = SUM;
    for (int i = 0; i < 10; i++) begin
      A = W'($urandom); B = W'($urandom); CIN = 1'($urandom); SUB = 1'($urandom);
      IN_VALID = 1'b1; OUT_READY = 1'b0;
      @(posedge CLK); @(negedge CLK);
      checks++; if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d]: got in_ready=%b out_valid=%b want 0 1", i, IN_READY, OUT_VALID);
      end
      checks++; if (SUM !== 16'h5230) begin errors++; $display("FAIL bp_sum[%0d]: got %h want 5230", i, SUM); end
    end
    checks++; if (held !== 16'h5230) begin errors++; $display("FAIL bp_first: got %h want 5230", held); end
    // Output handshake with a pending request: only the pop happens this edge.
    A = 16'h1111; B = 16'h2222; CIN = 1'b0; SUB = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
    @(posedge CLK); @(negedge CLK);
    OUT_READY = 1'b0;
    checks++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", IN_READY, OUT_VALID);
    end
    @(posedge CLK); @(negedge CLK);
    IN_VALID = 1'b0;
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL bp_accept: IN_READY got %b want 0", IN_READY); end
    wait_result(lat, to);
    ref_model(16'h1111, 16'h2222, 1'b0, 1'b0, es, ec, eo);
    checks++; if (to || SUM !== es || COUT !== ec || OVF !== eo) begin
      errors++; $display("FAIL bp_next_op: got to=%b sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", to, SUM, COUT, OVF, es, ec, eo);
    end
    pop();
  endtask

  task automatic test_reset_mid();
    bit to;
    int lat;
    start_op(16'hABCD, 16'h1357, 1'b1, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL rm_accept: timed out waiting for IN_READY"); return; end
    repeat (2) begin @(posedge CLK); @(negedge CLK); end
    RST_N = 1'b0;
    @(posedge CLK); @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b want 0", OUT_VALID); end
    checks++; if (SUM !== '0)         begin errors++; $display("FAIL rm_sum: got %h want 0", SUM); end
    checks++; if (IN_READY !== 1'b0)  begin errors++; $display("FAIL rm_in_ready: got %b want 0", IN_READY); end
    RST_N = 1'b1;
    #1;
    checks++; if (IN_READY !== 1'b1)  begin errors++; $display("FAIL rm_release: got %b want 1", IN_READY); end
    @(negedge CLK);
    start_op(16'h1234, 16'h1111, 1'b0, 1'b0, to);
    wait_result(lat, to);
    checks++; if (to || SUM !== 16'h2345 || COUT !== 1'b0 || OVF !== 1'b0) begin
      errors++; $display("FAIL rm_after: got to=%b sum=%h cout=%b ovf=%b want sum=2345 cout=0 ovf=0", to, SUM, COUT, OVF);
    end
    pop();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, es;
    logic         cin, sub, ec, eo;
    bit           to;
    int           lat, stall, fails0;
    fails0 = errors;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      if (i % 8 == 0) a = (i % 16 == 0) ? 16'h8000 : 16'h7FFF;
      ref_model(a, b, cin, sub, es, ec, eo);
      start_op(a, b, cin, sub, to);
      checks++; if (to) begin errors++; $display("FAIL b2b_accept[%0d]: timed out", i); break; end
      wait_result(lat, to);
      checks++; if (to) begin errors++; $display("FAIL b2b_done[%0d]: timed out", i); break; end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        A = W'($urandom); B = W'($urandom); IN_VALID = 1'b1;
        @(posedge CLK); @(negedge CLK);
      end
      checks++; if (SUM !== es)  begin errors++; $display("FAIL b2b_sum[%0d]: a=%h b=%h cin=%b sub=%b got %h want %h", i, a, b, cin, sub, SUM, es); end
      checks++; if (COUT !== ec) begin errors++; $display("FAIL b2b_cout[%0d]: a=%h b=%h sub=%b got %b want %b", i, a, b, sub, COUT, ec); end
      checks++; if (OVF !== eo)  begin errors++; $display("FAIL b2b_ovf[%0d]: a=%h b=%h sub=%b got %b want %b", i, a, b, sub, OVF, eo); end
      // Garbage request stays asserted through the pop edge; it must not be taken.
      A = W'($urandom); B = W'($urandom); IN_VALID = 1'b1;
      pop();
      checks++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
        errors++; $display("FAIL b2b_pop[%0d]: got out_valid=%b in_ready=%b want 0 1", i, OUT_VALID, IN_READY);
      end
      if (errors - fails0 > 20) break;
    end
    IN_VALID = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    A = '0; B = '0; CIN = 1'b0; SUB = 1'b0;
    @(negedge CLK);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
